serial_twos_complement: RTL and testbench

Bit-serial, parametrised two's-complement unit. It succeeds the fixed 4-bit combinational negator.
- Accepts a WIDTH-bit word on a start pulse.
- Processes one bit per clock, LSB first, using the copy-through-first-one-then-invert rule.
- Returns the negated or absolute value with a done pulse and an overflow flag.
- Used where area matters more than latency, e.g. sign conversion ahead of serial arithmetic blocks.

---
 rtl/serial_twos_complement_pkg.sv | 17 +
 rtl/serial_twos_complement_bit_cell.sv | 13 +
 rtl/serial_twos_complement.sv | 126 ++++++++++++
 tb/tb_serial_twos_complement.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_twos_complement_pkg.sv
// rtl/serial_twos_complement_pkg.sv - shared types and constants for the bit-serial two's-complement unit
package serial_twos_complement_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic MODE_NEG = 1'b0;
    localparam logic MODE_ABS = 1'b1;

    // Most-negative value of a w-bit word, i.e. the only value whose negation wraps.
    function automatic logic [31:0] most_neg(input int w);
        return 32'h1 << (w - 1);
    endfunction

endpackage

// File: rtl/serial_twos_complement_bit_cell.sv
// rtl/serial_twos_complement_bit_cell.sv - per-bit copy-through-first-one-then-invert rule
module twos_comp_bit_cell (
    input  logic b,
    input  logic neg,
    input  logic seen_one,
    output logic obit,
    output logic seen_one_next
);

    assign obit          = (neg && seen_one) ? ~b : b;
    assign seen_one_next = seen_one | b;

endmodule

// File: rtl/serial_twos_complement.sv
// rtl/serial_twos_complement.sv - bit-serial negate/absolute-value unit; SERIAL_TWOS_COMPLEMENT_SEROUT_EN adds a serial result stream
module serial_twos_complement
    import serial_twos_complement_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic             Mode,
    input  logic [WIDTH-1:0] In,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Out,
`ifdef SERIAL_TWOS_COMPLEMENT_SEROUT_EN
    output logic             SerOut,
    output logic             SerValid,
`endif
    output logic             Overflow
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = WIDTH'(most_neg(WIDTH));

    state_t           state;
    logic [WIDTH-1:0] sreg;
    // Holds only the WIDTH-1 bits already produced; the final bit goes straight to Out.
    logic [WIDTH-2:0] res_q;
    logic [CNT_W-1:0] count;
    logic             seen_one;
    logic             neg;
    logic             ovf_cand;
    logic             busy_q;
    logic             done_q;
    logic             ovf_q;
    logic [WIDTH-1:0] out_q;

    logic             obit;
    logic             seen_one_next;
    logic [WIDTH-1:0] res_next;
    logic             neg_now;

    twos_comp_bit_cell u_cell (
        .b             (sreg[0]),
        .neg           (neg),
        .seen_one      (seen_one),
        .obit          (obit),
        .seen_one_next (seen_one_next)
    );

    assign res_next = {obit, res_q};
    assign neg_now  = (Mode == MODE_NEG) ? 1'b1 : In[WIDTH-1];

`ifdef SERIAL_TWOS_COMPLEMENT_SEROUT_EN
    logic ser_out_q;
    logic ser_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
        end else begin
            ser_valid_q <= (state == SHIFT);
            if (state == SHIFT) begin
                ser_out_q <= obit;
            end
        end
    end

    assign SerOut   = ser_out_q;
    assign SerValid = ser_valid_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sreg     <= '0;
            res_q    <= '0;
            count    <= '0;
            seen_one <= 1'b0;
            neg      <= 1'b0;
            ovf_cand <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            out_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        sreg     <= In;
                        res_q    <= '0;
                        count    <= '0;
                        seen_one <= 1'b0;
                        neg      <= neg_now;
                        ovf_cand <= (In == MOST_NEG) && neg_now;
                        busy_q   <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    sreg     <= sreg >> 1;
                    res_q    <= res_next[WIDTH-1:1];
                    seen_one <= seen_one_next;
                    count    <= count + 1'b1;
                    if (count == LAST) begin
                        out_q  <= res_next;
                        ovf_q  <= ovf_cand;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Busy     = busy_q;
    assign Done     = done_q;
    assign Out      = out_q;
    assign Overflow = ovf_q;

endmodule

// File: tb/tb_serial_twos_complement.sv
// tb/tb_serial_twos_complement.sv - directed self-checking bench for serial_twos_complement (WIDTH=8 and WIDTH=4)
module tb_serial_twos_complement;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0;
    logic       mode8 = 1'b0;
    logic [7:0] in8 = '0;
    logic       busy8, done8, ovf8;
    logic [7:0] out8;

    logic       start4 = 1'b0;
    logic       mode4 = 1'b0;
    logic [3:0] in4 = '0;
    logic       busy4, done4, ovf4;
    logic [3:0] out4;

`ifdef SERIAL_TWOS_COMPLEMENT_SEROUT_EN
    logic       ser8, sval8, ser4, sval4;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_twos_complement #(.WIDTH(8)) dut8 (
        .clk      (clk),
        .rst      (rst),
        .Start    (start8),
        .Mode     (mode8),
        .In       (in8),
        .Busy     (busy8),
        .Done     (done8),
        .Out      (out8),
`ifdef SERIAL_TWOS_COMPLEMENT_SEROUT_EN
        .SerOut   (ser8),
        .SerValid (sval8),
`endif
        .Overflow (ovf8)
    );

    serial_twos_complement #(.WIDTH(4)) dut4 (
        .clk      (clk),
        .rst      (rst),
        .Start    (start4),
        .Mode     (mode4),
        .In       (in4),
        .Busy     (busy4),
        .Done     (done4),
        .Out      (out4),
`ifdef SERIAL_TWOS_COMPLEMENT_SEROUT_EN
        .SerOut   (ser4),
        .SerValid (sval4),
`endif
        .Overflow (ovf4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
            $error("check %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start a WIDTH=8 conversion, return cycles to Done and number of Busy cycles before it.
    task automatic run8(input logic m, input logic [7:0] v, output int cyc, output int bc);
        mode8  = m;
        in8    = v;
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        bc  = busy8 ? 1 : 0;
        cyc = 0;
        while (cyc < 40) begin
            step();
            cyc++;
            if (done8) break;
            if (busy8) bc++;
        end
    endtask

    initial begin
        int         cyc;
        int         bc;
        logic [7:0] seq [4];
        logic [3:0] exp4;
        logic [3:0] sword;
        int         scnt;

        step();
        step();
        rst = 1'b0;
        chk("reset_busy", 32'(busy8), 32'h0);
        chk("reset_done", 32'(done8), 32'h0);
        chk("reset_out", 32'(out8), 32'h0);
        chk("reset_ovf", 32'(ovf8), 32'h0);

        // Negate 5: Done exactly 8 cycles after the accepting edge.
        run8(1'b0, 8'h05, cyc, bc);
        chk("neg05_latency", 32'(cyc), 32'd8);
        chk("neg05_busy_cycles", 32'(bc), 32'd8);
        chk("neg05_busy_at_done", 32'(busy8), 32'h0);
        chk("neg05_out", 32'(out8), 32'hFB);
        chk("neg05_ovf", 32'(ovf8), 32'h0);
        step();
        chk("neg05_done_one_cycle", 32'(done8), 32'h0);
        chk("neg05_out_held", 32'(out8), 32'hFB);

        run8(1'b0, 8'h80, cyc, bc);
        chk("neg80_out", 32'(out8), 32'h80);
        chk("neg80_ovf", 32'(ovf8), 32'h1);
        run8(1'b1, 8'hF6, cyc, bc);
        chk("absF6_out", 32'(out8), 32'h0A);
        chk("absF6_ovf", 32'(ovf8), 32'h0);
        run8(1'b1, 8'h3C, cyc, bc);
        chk("abs3C_out", 32'(out8), 32'h3C);
        chk("abs3C_ovf", 32'(ovf8), 32'h0);
        run8(1'b0, 8'h00, cyc, bc);
        chk("neg00_out", 32'(out8), 32'h00);

        // Start during Busy is ignored.
        mode8 = 1'b0; in8 = 8'h12; start8 = 1'b1;
        step();
        start8 = 1'b0;
        step(); step();
        in8 = 8'h77; start8 = 1'b1;
        step();
        start8 = 1'b0;
        chk("ignore_out_held", 32'(out8), 32'h00);
        cyc = 3;
        while (cyc < 40) begin
            step();
            cyc++;
            if (done8) break;
        end
        chk("ignore_latency", 32'(cyc), 32'd8);
        chk("ignore_out", 32'(out8), 32'hEE);
        step();
        step();
        chk("ignore_no_second_done", 32'(busy8), 32'h0);

        // Reset at t+4 aborts the conversion.
        mode8 = 1'b0; in8 = 8'h55; start8 = 1'b1;
        step();
        start8 = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", 32'(busy8), 32'h0);
        chk("abort_out", 32'(out8), 32'h0);
        chk("abort_ovf", 32'(ovf8), 32'h0);
        bc = 0;
        for (int i = 0; i < 10; i++) begin
            if (done8) bc++;
            step();
        end
        chk("abort_no_done", 32'(bc), 32'h0);
        run8(1'b0, 8'h01, cyc, bc);
        chk("after_abort_out", 32'(out8), 32'hFF);

        // Back-to-back with Start held high.
        seq[0] = 8'h01; seq[1] = 8'h7F; seq[2] = 8'h33; seq[3] = 8'hC0;
        mode8 = 1'b0; in8 = seq[0]; start8 = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            cyc = 0;
            while (cyc < 40) begin
                step();
                cyc++;
                if (done8) break;
            end
            chk("b2b_spacing", 32'(cyc), 32'd8);
            case (i)
                0: chk("b2b_out0", 32'(out8), 32'hFF);
                1: chk("b2b_out1", 32'(out8), 32'h81);
                default: chk("b2b_out2", 32'(out8), 32'hCD);
            endcase
            in8 = seq[i+1];
            step();
            chk("b2b_restart_busy", 32'(busy8), 32'h1);
        end
        start8 = 1'b0;

        // WIDTH=4 exhaustive sweep, both modes.
        for (int m = 0; m < 2; m++) begin
            for (int v = 0; v < 16; v++) begin
                in4 = 4'(v);
                mode4 = m[0];
                exp4 = (m == 0 || in4[3]) ? 4'(-v) : 4'(v);
                start4 = 1'b1;
                step();
                start4 = 1'b0;
                cyc = 0;
                scnt = 0;
                sword = '0;
                while (cyc < 20) begin
                    step();
                    cyc++;
`ifdef SERIAL_TWOS_COMPLEMENT_SEROUT_EN
                    if (sval4) begin
                        if (scnt < 4) sword[scnt] = ser4;
                        scnt++;
                    end
`endif
                    if (done4) break;
                end
                chk("w4_latency", 32'(cyc), 32'd4);
                chk($sformatf("w4_out_m%0d_in%0d", m, v), 32'(out4), 32'(exp4));
                chk($sformatf("w4_ovf_m%0d_in%0d", m, v), 32'(ovf4), (v == 8) ? 32'h1 : 32'h0);
`ifdef SERIAL_TWOS_COMPLEMENT_SEROUT_EN
                chk("w4_ser_count", 32'(scnt), 32'd4);
                chk("w4_ser_word", 32'(sword), 32'(exp4));
`endif
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
